// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the memory-side responder: request/response
// structs, access-size encodings and the responder state enum.
package dbus_responder_pkg;

    localparam int DBUS_RESP_MAX_LAT = 15;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_RESP = 2'd2
    } resp_state_t;

    // Encodings above MSIZE8 are treated as misaligned so they raise err.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input msize_t size);
        logic bad;
        case (size)
            MSIZE1:  bad = 1'b0;
            MSIZE2:  bad = addr_lo[0];
            MSIZE4:  bad = |addr_lo[1:0];
            MSIZE8:  bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Core data-bus request/response pair; the core drives dreq, the responder drives dresp.
interface dbus_responder_if;
    import dbus_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_resp_mem.sv
// Byte-strobed 64-bit word array with a full-word backdoor write port.
module dbus_resp_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  logic [7:0]    wstrb,
    input  logic [63:0]   wdata,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_idx,
    input  logic [63:0]   bd_data,
    input  logic [AW-1:0] ridx,
    output logic [63:0]   rdata
);
    logic [63:0] mem [DEPTH];

    // Transaction lanes are written after the backdoor so they win on a collision.
    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: captures one request, answers after LAT cycles.
// Optional DBUS_RESP_RAND_LAT_EN adds 0..3 LFSR-driven extra wait cycles.
//
// state     | meaning
// RESP_IDLE | waiting for dreq.valid; addr_ok on capture
// RESP_WAIT | counting down remaining latency; valid drop aborts
// RESP_RESP | data_ok pulse; write commits at the closing edge
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int          DEPTH = 1024,
    parameter logic [63:0] BASE  = 64'h8000_0000,
    parameter int          LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    dbus_responder_if.slave  bus,
    input  logic             bd_we,
    input  logic [63:0]      bd_addr,
    input  logic [63:0]      bd_data,
    output logic             err
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = 5;
    localparam logic [63:0] SPAN      = 64'(DEPTH) * 64'd8;
    localparam logic [CW-1:0] LOAD_BASE = CW'(LAT - 1);

    if (LAT < 1 || LAT > DBUS_RESP_MAX_LAT) begin : g_bad_lat
        $error("dbus_responder: LAT must be within 1..15");
    end

    resp_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, load;
    logic [AW-1:0] idx_q;
    logic          in_rng_q, wr_q, err_q;
    logic [7:0]    strobe_q;
    logic [63:0]   wdata_q, rdata;
    logic          capture, abort, commit;
    logic [63:0]   req_off, bd_off;
    logic          req_in_rng, bd_in_rng;
    dbus_resp_t    resp;

    assign req_off    = bus.dreq.addr - BASE;
    assign req_in_rng = (bus.dreq.addr >= BASE) && (req_off < SPAN);
    assign bd_off     = bd_addr - BASE;
    assign bd_in_rng  = (bd_addr >= BASE) && (bd_off < SPAN);

`ifdef DBUS_RESP_RAND_LAT_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign load = LOAD_BASE + CW'(lfsr_q[1:0]);
`else
    assign load = LOAD_BASE;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        abort   = 1'b0;
        commit  = 1'b0;
        resp    = '0;
        case (state_q)
            RESP_IDLE: begin
                if (bus.dreq.valid) begin
                    capture      = 1'b1;
                    resp.addr_ok = 1'b1;
                    cnt_d        = load;
                    state_d      = (load == '0) ? RESP_RESP : RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                if (!bus.dreq.valid) begin
                    abort   = 1'b1;
                    state_d = RESP_IDLE;
                end else begin
                    // cnt_q holds the WAIT cycles still to spend, this one included
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CW'(1)) state_d = RESP_RESP;
                end
            end
            RESP_RESP: begin
                resp.data_ok = 1'b1;
                resp.data    = (in_rng_q && !wr_q) ? rdata : 64'd0;
                commit       = wr_q && in_rng_q;
                state_d      = RESP_IDLE;
            end
            default: state_d = RESP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RESP_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            in_rng_q <= 1'b0;
            wr_q     <= 1'b0;
            strobe_q <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q    <= req_off[3 +: AW];
                in_rng_q <= req_in_rng;
                wr_q     <= |bus.dreq.strobe;
                strobe_q <= bus.dreq.strobe;
                wdata_q  <= bus.dreq.data;
            end
            if (abort || (capture && (!req_in_rng ||
                          is_misaligned(bus.dreq.addr[2:0], bus.dreq.size))))
                err_q <= 1'b1;
        end
    end

    assign bus.dresp = resp;
    assign err       = err_q;

    dbus_resp_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .we      (commit),
        .widx    (idx_q),
        .wstrb   (strobe_q),
        .wdata   (wdata_q),
        .bd_we   (bd_we && bd_in_rng),
        .bd_idx  (bd_off[3 +: AW]),
        .bd_data (bd_data),
        .ridx    (idx_q),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder with the default DEPTH/BASE/LAT=2.
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bd_we = 1'b0;
    logic [63:0] bd_addr = '0;
    logic [63:0] bd_data = '0;
    logic        err;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    dbus_responder_if bus();

    dbus_responder dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .bd_we   (bd_we),
        .bd_addr (bd_addr),
        .bd_data (bd_data),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic backdoor(input logic [63:0] a, input logic [63:0] d);
        tick();
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    // Presents a request and holds it until data_ok; returns in the data_ok cycle.
    task automatic access(input string tag, input logic [63:0] a, input logic [2:0] sz,
                          input logic [7:0] st, input logic [63:0] d,
                          output logic [63:0] rd, output int lat, output int done_cyc);
        tick();
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = a;
        bus.dreq.size   = msize_t'(sz);
        bus.dreq.strobe = st;
        bus.dreq.data   = d;
        #1;
        chk({tag, ".addr_ok"}, 64'(bus.dresp.addr_ok), 64'd1);
        chk({tag, ".early_data_ok"}, 64'(bus.dresp.data_ok), 64'd0);
        lat = 0;
        while (!bus.dresp.data_ok && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, ".data_ok_seen"}, 64'(bus.dresp.data_ok), 64'd1);
`ifdef DBUS_RESP_RAND_LAT_EN
        chk({tag, ".lat_range"}, 64'(lat >= 2 && lat <= 5), 64'd1);
`else
        chk({tag, ".lat"}, 64'(lat), 64'd2);
`endif
        rd = bus.dresp.data;
        done_cyc = cyc;
    endtask

    task automatic idle();
        tick();
        bus.dreq.valid  = 1'b0;
        bus.dreq.strobe = '0;
        #1;
    endtask

    initial begin
        logic [63:0] rd;
        int lat, c1, c2, lat2;

        bus.dreq = '0;
        repeat (2) tick();
        chk("rst.addr_ok", 64'(bus.dresp.addr_ok), 64'd0);
        chk("rst.data_ok", 64'(bus.dresp.data_ok), 64'd0);
        chk("rst.data", bus.dresp.data, 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        reset = 1'b1;

        backdoor(64'h8000_0010, 64'h1122_3344_5566_7788);
        access("rd1", 64'h8000_0010, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("rd1.data", rd, 64'h1122_3344_5566_7788);
        chk("rd1.err", 64'(err), 64'd0);
        idle();
        chk("rd1.data_ok_pulse", 64'(bus.dresp.data_ok), 64'd0);

        access("wr1", 64'h8000_0010, 3'd3, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, rd, lat, c1);
        chk("wr1.data", rd, 64'd0);
        idle();
        access("rb1", 64'h8000_0010, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("rb1.data", rd, 64'h1122_3344_CCCC_DDDD);
        chk("rb1.err", 64'(err), 64'd0);
        idle();

        // reset asserted while the responder is waiting on a read
        tick();
        bus.dreq.valid = 1'b1; bus.dreq.addr = 64'h8000_0010;
        bus.dreq.size = MSIZE8; bus.dreq.strobe = '0;
        tick();
        reset = 1'b0;
        bus.dreq.valid = 1'b0;
        #1;
        chk("rstw.data_ok0", 64'(bus.dresp.data_ok), 64'd0);
        tick();
        chk("rstw.data_ok1", 64'(bus.dresp.data_ok), 64'd0);
        reset = 1'b1;
        access("rstw.rb", 64'h8000_0010, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("rstw.word", rd, 64'h1122_3344_CCCC_DDDD);
        idle();

        // write abandoned mid-wait
        tick();
        bus.dreq.valid = 1'b1; bus.dreq.addr = 64'h8000_0010; bus.dreq.size = MSIZE8;
        bus.dreq.strobe = 8'hFF; bus.dreq.data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus.dreq.valid = 1'b0;
        #1;
        chk("abort.data_ok0", 64'(bus.dresp.data_ok), 64'd0);
        tick();
        chk("abort.data_ok1", 64'(bus.dresp.data_ok), 64'd0);
        chk("abort.err", 64'(err), 64'd1);
        repeat (3) tick();
        chk("abort.data_ok_late", 64'(bus.dresp.data_ok), 64'd0);
        access("abort.rb", 64'h8000_0010, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("abort.word", rd, 64'h1122_3344_CCCC_DDDD);
        idle();

        do_reset();
        chk("rst2.err", 64'(err), 64'd0);
        access("al4", 64'h8000_0014, 3'd2, 8'h00, 64'd0, rd, lat, c1);
        chk("al4.data", rd, 64'h1122_3344_CCCC_DDDD);
        chk("al4.err", 64'(err), 64'd0);
        idle();
        access("mis8", 64'h8000_0014, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("mis8.data", rd, 64'h1122_3344_CCCC_DDDD);
        chk("mis8.err", 64'(err), 64'd1);
        idle();

        do_reset();
        backdoor(64'h8000_0000, 64'h0123_4567_89AB_CDEF);
        backdoor(64'h8000_1FF8, 64'hFEED_FACE_CAFE_BEEF);
        access("last", 64'h8000_1FF8, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("last.data", rd, 64'hFEED_FACE_CAFE_BEEF);
        chk("last.err", 64'(err), 64'd0);
        idle();
        access("low", 64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("low.data", rd, 64'd0);
        chk("low.err", 64'(err), 64'd1);
        idle();
        access("high.wr", 64'h8000_2000, 3'd3, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, rd, lat, c1);
        idle();
        access("word0", 64'h8000_0000, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("word0.data", rd, 64'h0123_4567_89AB_CDEF);
        idle();
        access("high.rd", 64'h8000_2000, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("high.data", rd, 64'd0);
        idle();
        repeat (4) tick();
        chk("err.sticky", 64'(err), 64'd1);

        do_reset();
        access("b2b.a", 64'h8000_0000, 3'd3, 8'h00, 64'd0, rd, lat, c1);
        chk("b2b.a.data", rd, 64'h0123_4567_89AB_CDEF);
        access("b2b.b", 64'h8000_1FF8, 3'd3, 8'h00, 64'd0, rd, lat2, c2);
        chk("b2b.b.data", rd, 64'hFEED_FACE_CAFE_BEEF);
`ifdef DBUS_RESP_RAND_LAT_EN
        chk("b2b.gap", 64'(c2 - c1), 64'(lat2 + 1));
`else
        chk("b2b.gap", 64'(c2 - c1), 64'd3);
`endif
        idle();
        chk("b2b.err", 64'(err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Memory-side responder for the core's data bus: accepts `dbus_req_t` requests from the core's memory stage and answers with `dbus_resp_t` after a configurable latency.
- Backed by a word-addressed on-chip array.
- Used as the simulation/FPGA data memory and as the reference responder for exercising the core's Dwait stall path without the full SoC interconnect.

Parameters:
- `DEPTH`, 1024, number of 64-bit words in the backing array (power of two).
- `BASE`, 64'h8000_0000, byte address mapped to word 0.
- `LAT`, 2, cycles from request capture to data_ok; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dreq`  in  `dbus_req_t`  request from core: valid, addr[63:0], size[2:0], strobe[7:0], data[63:0].
- `dresp`  out  `dbus_resp_t`  response: addr_ok, data_ok, data[63:0].
- `bd_we`  in  1  backdoor write enable (bench preload).
- `bd_addr`  in  64  backdoor byte address, 8-byte aligned.
- `bd_data`  in  64  backdoor write data.
- `err`  out  1  sticky protocol/range error flag.

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, err=0. Array contents are not cleared.
- FSM states:
  - IDLE: when dreq.valid=1, capture addr/size/strobe/data, assert addr_ok combinationally that cycle, load counter=LAT-1, go to WAIT (or RESP if LAT=1).
  - WAIT: counter decrements each cycle; at 0 go to RESP. If dreq.valid drops, set err, go to IDLE, and suppress the write.
  - RESP: data_ok=1 for exactly one cycle; next state IDLE unconditionally.
- Timing: request first seen valid in cycle t → data_ok in cycle t+LAT. A new request is accepted no earlier than cycle t+LAT+1.
- Captured fields are authoritative. Changes on dreq.addr/data while in WAIT are ignored and are not errors.
- Word index = (addr − BASE) >> 3, truncated to log2(DEPTH) bits after a range check.
  - Out of range means addr < BASE or addr ≥ BASE+8·DEPTH. Then: read data = 0, write dropped, err set, data_ok still issued.
- Read (strobe == 0): dresp.data = full aligned 64-bit word during the RESP cycle. The core performs byte/half/word extraction.
- Write (strobe != 0): byte lane i updated iff strobe[i], at the clock edge closing the RESP cycle. dresp.data = 0 on writes.
- Misalignment: size not matching a naturally aligned access (e.g. size=3 with addr[2:0] != 0) sets err. Access still proceeds on the aligned word.
- Backdoor write: bd_we writes bd_data to the word at bd_addr at the next edge. If it hits the same word as a committing transaction write in the same cycle, the transaction write wins.
- data_ok and addr_ok are 0 in all states not listed above.

Optional Feature:
- `DBUS_RESP_RAND_LAT_EN`:
  - Defined: 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle. At capture, extra = lfsr[1:0] is added, giving counter load LAT-1+extra and latency LAT..LAT+3.
  - Undefined: fixed latency LAT; no LFSR logic.

Decomposition:
- `dbus_req_t`, `dbus_resp_t`, `msize_t` and the size encodings stay in the common package.
- Add `DBUS_RESP_MAX_LAT` and the responder state enum (IDLE/WAIT/RESP) to the common package.
- One natural sub-module: `dbus_resp_mem`, the byte-strobed single-port array with backdoor port.

Test Plan:
- Reset mid-WAIT: issue a read, drop reset in cycle t+1 → next cycle data_ok=0, state IDLE; preloaded word unchanged.
- Read, LAT=2: backdoor 0x1122334455667788 to 0x8000_0010; read 0x8000_0010 at t → addr_ok at t, data_ok only at t+2, data=0x1122334455667788.
- Strobed write: write 0xAAAA_BBBB_CCCC_DDDD, strobe 8'h0F, to 0x8000_0010 over the preload above; read back → 0x11223344CCCCDDDD; err=0.
- Out of range: read 0x7FFF_FFF8 → data_ok after LAT, data=0, err=1 and it stays 1 until reset.
- Protocol abort: valid drops in WAIT on a write → no data_ok, word unchanged, err=1.
- Back-to-back: core-style valid held until data_ok, then new request next cycle → two data_ok pulses LAT+1 cycles apart. With `DBUS_RESP_RAND_LAT_EN`, each latency is in [2,5].
